// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle for mem_arbiter.
// The arbiter uses the slave view; the surrounding core/memory use the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_ack, mem_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_ack, mem_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: latches one request, runs a req/ack handshake, aborts on timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         owner,
  output logic         err
);
  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ABORT_DATA = {DATA_W/32{32'hDEAD_BEEF}};

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             grant, winner, finish, timeout;

`ifdef MEM_ARB_RR_EN
  logic rr_last_q;

  // Reset value makes port 0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rr_last_q <= 1'b1;
    else if (grant) rr_last_q <= winner;
  end

  always_comb winner = (bus.m0_req && bus.m1_req) ? ~rr_last_q : bus.m1_req;
`else
  always_comb winner = bus.m1_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack on the last allowed cycle still wins over the abort.
        if (bus.mem_ack) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          finish  = 1'b1;
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every one of them samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner         <= 1'b0;
      err           <= 1'b0;
      cnt_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_done   <= 1'b0;
      bus.m1_done   <= 1'b0;
      // NOTE: rdata is a pair of visible output registers, not a RAM, so it is reset like any flop.
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_gnt  <= grant && !winner;
      bus.m1_gnt  <= grant && winner;
      bus.m0_done <= finish && !owner;
      bus.m1_done <= finish && owner;
      err         <= timeout;

      if (grant) begin
        owner         <= winner;
        bus.mem_we    <= winner ? bus.m1_we    : bus.m0_we;
        bus.mem_addr  <= winner ? bus.m1_addr  : bus.m0_addr;
        bus.mem_wdata <= winner ? bus.m1_wdata : bus.m0_wdata;
      end

      if (state_q == ST_WAIT) cnt_q <= finish ? '0 : cnt_q + CNT_W'(1);

      // Writes leave rdata alone unless the transaction was aborted.
      if (finish && (timeout || !bus.mem_we)) begin
        if (owner) bus.m1_rdata <= timeout ? ABORT_DATA : bus.mem_rdata;
        else       bus.m0_rdata <= timeout ? ABORT_DATA : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req = (state_q == ST_WAIT);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy, owner, err;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .owner (owner),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1, mrd;
    int            d;          // mem_ack arrives in WAIT cycle d (beyond TO+1 means never)
    logic          ack_idle;   // stray mem_ack while still IDLE
    logic          exp_win;
    int            exp_lat;    // cycles from gnt to done
    logic          exp_err;
    logic [DW-1:0] exp_rd0, exp_rd1;
  } txn_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic          m_last;
  logic [DW-1:0] m_rd [2];
  txn_t          tbl [8];
  logic [1:0]    hold_exp [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic r0, r1, we0, we1, input logic [AW-1:0] a0, a1,
                              input logic [DW-1:0] wd0, wd1, mrd, input int d,
                              input logic ack_idle, win, input int lat, input logic e,
                              input logic [DW-1:0] rd0, rd1);
    txn_t t;
    t.r0 = r0; t.r1 = r1; t.we0 = we0; t.we1 = we1; t.addr0 = a0; t.addr1 = a1;
    t.wd0 = wd0; t.wd1 = wd1; t.mrd = mrd; t.d = d; t.ack_idle = ack_idle;
    t.exp_win = win; t.exp_lat = lat; t.exp_err = e; t.exp_rd0 = rd0; t.exp_rd1 = rd1;
    return t;
  endfunction

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    m_last  = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  // Applies one transaction from IDLE and checks grant, latched bus, latency and result.
  task automatic run_txn(input txn_t t, input string id);
    logic early;
    early = 1'b0;
    bus.m0_req = t.r0; bus.m0_we = t.we0; bus.m0_addr = t.addr0; bus.m0_wdata = t.wd0;
    bus.m1_req = t.r1; bus.m1_we = t.we1; bus.m1_addr = t.addr1; bus.m1_wdata = t.wd1;
    bus.mem_ack = t.ack_idle; bus.mem_rdata = t.mrd;
    step();
    check({id, " gnt"}, 64'({bus.m1_gnt, bus.m0_gnt}), 64'(t.exp_win ? 2'b10 : 2'b01));
    check({id, " req_busy"}, 64'({bus.mem_req, busy}), 64'(2'b11));
    check({id, " owner"}, 64'(owner), 64'(t.exp_win));
    check({id, " mem_we"}, 64'(bus.mem_we), 64'(t.exp_win ? t.we1 : t.we0));
    check({id, " mem_addr"}, 64'(bus.mem_addr), 64'(t.exp_win ? t.addr1 : t.addr0));
    check({id, " mem_wdata"}, 64'(bus.mem_wdata), 64'(t.exp_win ? t.wd1 : t.wd0));
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    for (int j = 1; j <= t.exp_lat; j++) begin
      bus.mem_ack = (j == t.d);
      if ((j > 1 && (bus.m0_gnt || bus.m1_gnt)) || bus.m0_done || bus.m1_done || err || !busy)
        early = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    check({id, " early_pulse"}, 64'(early), 64'(0));
    check({id, " done"}, 64'({bus.m1_done, bus.m0_done}), 64'(t.exp_win ? 2'b10 : 2'b01));
    check({id, " err"}, 64'(err), 64'(t.exp_err));
    check({id, " idle"}, 64'({bus.mem_req, busy}), 64'(2'b00));
    check({id, " last_owner"}, 64'(owner), 64'(t.exp_win));
    check({id, " m0_rdata"}, 64'(bus.m0_rdata), 64'(t.exp_rd0));
    check({id, " m1_rdata"}, 64'(bus.m1_rdata), 64'(t.exp_rd1));
  endtask

  // Reference model: who wins, how long it takes, and what each port's rdata becomes.
  task automatic make_rand(output txn_t t);
    int   sel;
    logic we_w;
    sel = $urandom_range(1, 3);
    t.r0 = sel[0]; t.r1 = sel[1];
    t.we0 = 1'($urandom_range(0, 1)); t.we1 = 1'($urandom_range(0, 1));
    t.addr0 = $urandom; t.addr1 = $urandom;
    t.wd0 = $urandom; t.wd1 = $urandom; t.mrd = $urandom;
    t.d = $urandom_range(1, TO + 3);
    t.ack_idle = 1'($urandom_range(0, 1));
    if (t.r0 && t.r1) begin
`ifdef MEM_ARB_RR_EN
      t.exp_win = !m_last;
`else
      t.exp_win = 1'b1;
`endif
    end else begin
      t.exp_win = t.r1;
    end
    m_last    = t.exp_win;
    t.exp_err = (t.d > TO + 1);
    t.exp_lat = t.exp_err ? TO + 1 : t.d;
    we_w      = t.exp_win ? t.we1 : t.we0;
    if (t.exp_err)  m_rd[t.exp_win] = 32'hDEAD_BEEF;
    else if (!we_w) m_rd[t.exp_win] = t.mrd;
    t.exp_rd0 = m_rd[0];
    t.exp_rd1 = m_rd[1];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;

    tbl[0] = mk(1, 0, 0, 0, 'h40, 'h0, 0, 0, 'h1234_5678, 3, 1, 0, 3, 0, 'h1234_5678, 0);
    tbl[1] = mk(0, 1, 0, 1, 'h0, 'h80, 0, 'hCAFE_F00D, 'hFFFF_FFFF, 2, 0, 1, 2, 0,
                'h1234_5678, 0);
`ifdef MEM_ARB_RR_EN
    tbl[2] = mk(1, 1, 0, 0, 'h100, 'h104, 0, 0, 'hA5A5_0001, 1, 1, 0, 1, 0, 'hA5A5_0001, 0);
    tbl[3] = mk(1, 1, 0, 0, 'h108, 'h10C, 0, 0, 'hA5A5_0002, 1, 0, 1, 1, 0,
                'hA5A5_0001, 'hA5A5_0002);
    hold_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    tbl[2] = mk(1, 1, 0, 0, 'h100, 'h104, 0, 0, 'hA5A5_0001, 1, 1, 1, 1, 0,
                'h1234_5678, 'hA5A5_0001);
    tbl[3] = mk(1, 1, 0, 0, 'h108, 'h10C, 0, 0, 'hA5A5_0002, 1, 0, 1, 1, 0,
                'h1234_5678, 'hA5A5_0002);
    hold_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    tbl[4] = mk(1, 0, 0, 0, 'h1F0, 0, 0, 0, 'h7777_7777, 9, 0, 0, 5, 1, 'hDEAD_BEEF, 'hA5A5_0002);
    tbl[5] = mk(0, 1, 0, 0, 0, 'h2F0, 0, 0, 'h0BAD_F00D, 5, 1, 1, 5, 0, 'hDEAD_BEEF, 'h0BAD_F00D);
    tbl[6] = mk(1, 0, 1, 0, 'h3F0, 0, 'h1111_2222, 0, 'h9999_9999, 4, 0, 0, 4, 0,
                'hDEAD_BEEF, 'h0BAD_F00D);
    tbl[7] = mk(0, 1, 0, 1, 0, 'h4F0, 0, 'h3333_4444, 'h9999_9999, 7, 0, 1, 5, 1,
                'hDEAD_BEEF, 'hDEAD_BEEF);

    // Reset state, sampled while reset is still asserted.
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    check("rst ctl", 64'({busy, owner, err, bus.mem_req, bus.mem_we}), 64'(0));
    check("rst pulses", 64'({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done}), 64'(0));
    check("rst mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'(0));
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset two cycles after a grant: everything drops at once, no done/err.
    do_reset();
    bus.m1_req = 1'b1; bus.m1_addr = 'h200;
    step();
    check("rstw pre_owner", 64'({owner, busy}), 64'(2'b11));
    bus.m1_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rstw async", 64'({bus.mem_req, busy, owner}), 64'(0));
    check("rstw no_pulse", 64'({bus.m0_done, bus.m1_done, err}), 64'(0));
    step();
    check("rstw held", 64'({bus.m0_done, bus.m1_done, err, busy}), 64'(0));
    reset = 1'b1;
    step();
    check("rstw released", 64'({bus.m0_done, bus.m1_done, err, busy}), 64'(0));
    m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
    run_txn(mk(1, 0, 0, 0, 'h44, 0, 0, 0, 'h55AA_55AA, 2, 0, 0, 2, 0, 'h55AA_55AA, 0), "rstw fresh");

    // Both requests held, memory acks in the first WAIT cycle: a grant every 2 cycles.
    do_reset();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.mem_rdata = 'h600D;
    for (int s = 1; s <= 8; s++) begin
      step();
      check($sformatf("hold gnt s%0d", s), 64'({bus.m1_gnt, bus.m0_gnt}),
            64'((s % 2 == 1) ? hold_exp[(s - 1) / 2] : 2'b00));
      check($sformatf("hold done s%0d", s), 64'({bus.m1_done, bus.m0_done}),
            64'((s % 2 == 0) ? hold_exp[s / 2 - 1] : 2'b00));
      bus.mem_ack = bus.mem_req;
      if (s == 8) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    step();
    check("hold drained", 64'({busy, bus.m0_gnt, bus.m1_gnt}), 64'(0));

    // Randomized transactions against the reference model.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      make_rand(t);
      run_txn(t, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
